// File: rtl/parity_frame_if.sv
// Producer-side handshake and serial-line signals of parity_frame_ctrl.
// The err_inject signal exists only when PAR_ERR_INJECT_EN is defined.
interface parity_frame_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              even_odd;
  logic              in_valid;
  logic              in_ready;
  logic              ser_out;
  logic              busy;
  logic              frame_done;
  logic              par_bit;
`ifdef PAR_ERR_INJECT_EN
  logic              err_inject;

  modport master (
    output data_in, even_odd, in_valid, err_inject,
    input  in_ready, ser_out, busy, frame_done, par_bit
  );
  modport slave (
    input  data_in, even_odd, in_valid, err_inject,
    output in_ready, ser_out, busy, frame_done, par_bit
  );
`else
  modport master (
    output data_in, even_odd, in_valid,
    input  in_ready, ser_out, busy, frame_done, par_bit
  );
  modport slave (
    input  data_in, even_odd, in_valid,
    output in_ready, ser_out, busy, frame_done, par_bit
  );
`endif
endinterface

// File: rtl/parity_frame_ctrl.sv
// Framed serial transmitter: start bit, data LSB first, parity bit, stop bit(s).
// Optional feature macro PAR_ERR_INJECT_EN adds err_inject to flip the parity of a frame.
module parity_frame_ctrl #(
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  parity_frame_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     tick, tick_next;
  logic [IW-1:0]     idx, idx_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              par_q, par_next;
  logic              ser_q, ser_next;
  logic              last_tick, final_stop, in_ready_c, accept, capture_par;

  assign last_tick  = (tick == CW'(CLKS_PER_BIT - 1));
  assign final_stop = (state == STOP) && last_tick && (idx == IW'(STOP_BITS - 1));
  assign in_ready_c = (state == IDLE) || final_stop;
  assign accept     = bus.in_valid && in_ready_c;

`ifdef PAR_ERR_INJECT_EN
  assign capture_par = (^bus.data_in) ^ bus.even_odd ^ bus.err_inject;
`else
  assign capture_par = (^bus.data_in) ^ bus.even_odd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      idx   <= '0;
      shreg <= '0;
      par_q <= 1'b0;
      ser_q <= 1'b1;
    end else begin
      state <= state_next;
      tick  <= tick_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      par_q <= par_next;
      ser_q <= ser_next;
    end
  end

  // idx counts data bits in DATA and stop bits in STOP; accepts happen only in IDLE or the final stop cycle
  always_comb begin
    state_next = state;
    tick_next  = tick;
    idx_next   = idx;
    shreg_next = shreg;
    par_next   = par_q;
    if (accept) begin
      shreg_next = bus.data_in;
      par_next   = capture_par;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          tick_next  = '0;
          idx_next   = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_next = DATA;
          tick_next  = '0;
          idx_next   = '0;
        end else begin
          tick_next = tick + CW'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          tick_next = '0;
          if (idx == IW'(DATA_W - 1)) begin
            state_next = PARITY;
            idx_next   = '0;
          end else begin
            idx_next   = idx + IW'(1);
            shreg_next = shreg >> 1;
          end
        end else begin
          tick_next = tick + CW'(1);
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_next = STOP;
          tick_next  = '0;
          idx_next   = '0;
        end else begin
          tick_next = tick + CW'(1);
        end
      end
      STOP: begin
        if (last_tick) begin
          tick_next = '0;
          if (final_stop) begin
            state_next = accept ? START : IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx + IW'(1);
          end
        end else begin
          tick_next = tick + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
        idx_next   = '0;
      end
    endcase
  end

  // ser_out is registered, so the line level is derived from where the FSM is going next
  always_comb begin
    ser_next = 1'b1;
    case (state_next)
      START:   ser_next = 1'b0;
      DATA:    ser_next = shreg_next[0];
      PARITY:  ser_next = par_next;
      default: ser_next = 1'b1;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.frame_done = final_stop;
  assign bus.busy       = (state != IDLE);
  assign bus.ser_out    = ser_q;
  assign bus.par_bit    = par_q;
endmodule
